// File: rtl/datain_unpack.sv
// Assembles four bytes from a host RX FIFO into a little-endian 32-bit command
// word and writes it to a command FIFO; a stalled partial word is dropped after a timeout.
module datain_unpack #(
  parameter int StateBitWidth_c = 3,
  parameter int TimeoutCycles_c = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifoin_empty,
  input  logic [7:0]                 fifoin_data,
  output logic                       fifoin_rd_en,
  input  logic                       fifoout_full,
  output logic                       fifoout_wr_en,
  output logic [31:0]                fifoout_data,
  output logic                       timeout_event,
  output logic [15:0]                drop_count,
  output logic [StateBitWidth_c-1:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    B1    = 3'b001,
    B2    = 3'b010,
    B3    = 3'b011,
    WRITE = 3'b100,
    DROP  = 3'b101
  } state_e;

  localparam logic [15:0] Limit_c = 16'(TimeoutCycles_c - 1);

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] drop_q, drop_d;
  logic        to_q, to_d;
  logic        init_q, init_d;
  logic        pop;

  // init_q keeps the FIFO untouched on the first cycle after reset release.
  always_comb begin
    pop = init_q && !fifoin_empty &&
          (state_q == IDLE || state_q == B1 || state_q == B2 || state_q == B3);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = 16'd0;
    drop_d  = drop_q;
    init_d  = 1'b1;
    case (state_q)
      IDLE, B1, B2, B3: begin
        if (pop) begin
          data_d[{state_q[1:0], 3'b000} +: 8] = fifoin_data;
          case (state_q)
            IDLE:    state_d = B1;
            B1:      state_d = B2;
            B2:      state_d = B3;
            default: state_d = WRITE;
          endcase
        end else if (state_q != IDLE && fifoin_empty) begin
          if (cnt_q == Limit_c) state_d = DROP;
          else                  cnt_d   = cnt_q + 16'd1;
        end
      end
      WRITE: if (!fifoout_full) state_d = IDLE;
      DROP: begin
        data_d  = 32'd0;
        drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered pulse that coincides with the DROP state.
    to_d = (state_d == DROP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 32'd0;
      cnt_q   <= 16'd0;
      drop_q  <= 16'd0;
      to_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      to_q    <= to_d;
      init_q  <= init_d;
    end
  end

  assign fifoin_rd_en  = pop;
  assign fifoout_wr_en = (state_q == WRITE) && !fifoout_full;
  assign fifoout_data  = data_q;
  assign timeout_event = to_q;
  assign drop_count    = drop_q;
  assign state         = StateBitWidth_c'(state_q);

endmodule

// File: tb/tb_datain_unpack.sv
// Randomized and directed bench for datain_unpack against a byte/word queue model.
module tb_datain_unpack;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifoin_empty = 1'b1;
  logic [7:0]  fifoin_data = 8'd0;
  logic        fifoin_rd_en;
  logic        fifoout_full = 1'b0;
  logic        fifoout_wr_en;
  logic [31:0] fifoout_data;
  logic        timeout_event;
  logic [15:0] drop_count;
  logic [2:0]  state;

  datain_unpack #(.StateBitWidth_c(3), .TimeoutCycles_c(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifoin_empty(fifoin_empty), .fifoin_data(fifoin_data), .fifoin_rd_en(fifoin_rd_en),
    .fifoout_full(fifoout_full), .fifoout_wr_en(fifoout_wr_en), .fifoout_data(fifoout_data),
    .timeout_event(timeout_event), .drop_count(drop_count), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Stimulus side: RX FIFO contents and controls applied once per cycle.
  logic [7:0]  rx[$];
  logic        full_ctl = 1'b0, rstn_ctl = 1'b0, pop_pend = 1'b0;

  // Reference model: bytes gathered so far, words awaiting the command FIFO.
  logic [31:0] pend[$];
  int          pend_c[$];
  logic [31:0] part = 32'd0;
  int          nb = 0, part_c = 0, gap = 0, mdrop = 0, cyc = 0, exp_st = 0;
  bit          drop_now = 0, fresh = 1, clr = 1, busy, exp_rd, exp_wr;

  logic [31:0] wr_log[$];
  int          lat_log[$];
  int          to_cnt = 0, pop_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    pop_pend = fifoin_rd_en;
    if (!rst_n) begin
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_rd_en", 32'(fifoin_rd_en), 32'd0);
      chk("rst_wr_en", 32'(fifoout_wr_en), 32'd0);
      chk("rst_timeout", 32'(timeout_event), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      chk("rst_data", fifoout_data, 32'd0);
      pend.delete(); pend_c.delete();
      nb = 0; gap = 0; drop_now = 0; fresh = 1; clr = 1; mdrop = 0;
    end else begin
      busy   = fresh || drop_now || (pend.size() > 0);
      exp_rd = !fifoin_empty && !busy;
      exp_wr = !drop_now && (pend.size() > 0) && !fifoout_full;
      exp_st = drop_now ? 5 : (pend.size() > 0) ? 4 : nb;
      chk("state", 32'(state), 32'(exp_st));
      chk("rd_en", 32'(fifoin_rd_en), 32'(exp_rd));
      chk("wr_en", 32'(fifoout_wr_en), 32'(exp_wr));
      chk("timeout_event", 32'(timeout_event), 32'(drop_now));
      chk("drop_count", 32'(drop_count), 32'(mdrop));
      if (pend.size() > 0) chk("word_data", fifoout_data, pend[0]);
      else if (clr)        chk("data_clear", fifoout_data, 32'd0);

      if (fifoout_wr_en) begin
        wr_log.push_back(fifoout_data);
        lat_log.push_back((pend_c.size() > 0) ? cyc - pend_c[0] : -1);
      end
      if (timeout_event) to_cnt++;
      if (fifoin_rd_en)  pop_cnt++;

      fresh = 0;
      if (drop_now) begin
        drop_now = 0; nb = 0; gap = 0; clr = 1;
        if (mdrop < 65535) mdrop++;
      end else if (exp_wr) begin
        void'(pend.pop_front()); void'(pend_c.pop_front());
      end
      if (exp_rd) begin
        if (nb == 0) begin part = 32'd0; part_c = cyc; end
        part[8*nb +: 8] = fifoin_data;
        nb++; gap = 0; clr = 0;
        if (nb == 4) begin pend.push_back(part); pend_c.push_back(part_c); nb = 0; end
      end else if (nb > 0 && !busy) begin
        gap++;
        if (gap == T) begin drop_now = 1; gap = 0; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (pop_pend && rx.size() > 0) void'(rx.pop_front());
    rst_n        = rstn_ctl;
    fifoin_empty = (rx.size() == 0);
    fifoin_data  = (rx.size() > 0) ? rx[0] : 8'($urandom);
    fifoout_full = full_ctl;
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    wr_log.delete(); lat_log.delete(); to_cnt = 0; pop_cnt = 0;
  endtask

  task automatic push4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rx.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_pops(input int n, input string nm);
    int b = 0;
    while (pop_cnt < n && b < 200) begin step(); b++; end
    chk(nm, 32'(pop_cnt >= n), 32'd1);
  endtask

  task automatic chk_word(input string nm, input int idx, input logic [31:0] w, input int lat);
    chk({nm, "_nwr"}, 32'(wr_log.size() > idx), 32'd1);
    if (wr_log.size() > idx) begin
      chk({nm, "_data"}, wr_log[idx], w);
      if (lat >= 0) chk({nm, "_lat"}, 32'(lat_log[idx]), 32'(lat));
    end
  endtask

  initial begin
    int gap_left = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    rstn_ctl = 1'b0;
    repeat (3) step();
    rstn_ctl = 1'b1;
    step();

    // Back-to-back word, 4-cycle latency.
    clear_logs();
    push4(32'h44332211);
    repeat (10) step();
    chk("t1_count", 32'(wr_log.size()), 32'd1);
    chk_word("t1", 0, 32'h44332211, 4);

    // Eight continuous bytes -> two words.
    clear_logs();
    for (int i = 0; i < 8; i++) rx.push_back(8'(i));
    repeat (16) step();
    chk("t2_count", 32'(wr_log.size()), 32'd2);
    chk_word("t2a", 0, 32'h03020100, 4);
    chk_word("t2b", 1, 32'h07060504, 4);

    // Command FIFO full for 10 WRITE cycles.
    clear_logs();
    full_ctl = 1'b1;
    push4(32'hA4A3A2A1);
    repeat (14) step();
    chk("t3_nowr", 32'(wr_log.size()), 32'd0);
    chk("t3_state", 32'(state), 32'd4);
    full_ctl = 1'b0;
    repeat (4) step();
    chk_word("t3", 0, 32'hA4A3A2A1, 14);

    // Two bytes then silence -> drop, then a clean word.
    clear_logs();
    rx.push_back(8'h55); rx.push_back(8'h66);
    wait_pops(2, "t4_pops");
    repeat (20) step();
    chk("t4_timeouts", 32'(to_cnt), 32'd1);
    chk("t4_drop_count", 32'(drop_count), 32'd1);
    chk("t4_data_cleared", fifoout_data, 32'd0);
    push4(32'hDDCCBBAA);
    repeat (10) step();
    chk_word("t4", 0, 32'hDDCCBBAA, 4);

    // Byte on the exact limit cycle wins over the drop.
    clear_logs();
    rx.push_back(8'h77); rx.push_back(8'h88);
    wait_pops(2, "t5_pops");
    repeat (15) step();
    rx.push_back(8'h99);
    step();
    chk("t5_limit_pop", 32'(pop_cnt), 32'd3);
    rx.push_back(8'hAA);
    repeat (8) step();
    chk("t5_timeouts", 32'(to_cnt), 32'd0);
    chk_word("t5", 0, 32'hAA998877, -1);

    // Reset while in B2 discards the partial word.
    clear_logs();
    rx.push_back(8'hC1); rx.push_back(8'hC2);
    wait_pops(2, "t6_pops");
    step();
    chk("t6_in_b2", 32'(state), 32'd2);
    rstn_ctl = 1'b0;
    step();
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_drops", 32'(drop_count), 32'd0);
    rstn_ctl = 1'b1;
    step();
    push4(32'hD4D3D2D1);
    repeat (10) step();
    chk("t6_timeouts", 32'(to_cnt), 32'd0);
    chk_word("t6", 0, 32'hD4D3D2D1, 4);

    // Randomized traffic with gaps around the timeout and random back-pressure.
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      full_ctl = ($urandom_range(0, 3) == 0);
      rstn_ctl = !(i >= 1500 && i < 1502);
      if (rx.size() < 2) begin
        if (gap_left == 0) begin
          rx.push_back(8'($urandom));
          case ($urandom_range(0, 5))
            3:       gap_left = $urandom_range(1, 4);
            4:       gap_left = $urandom_range(14, 18);
            5:       gap_left = $urandom_range(20, 40);
            default: gap_left = 0;
          endcase
        end else gap_left--;
      end
      step();
    end
    full_ctl = 1'b0;
    repeat (40) step();
    chk("rand_writes_seen", 32'(wr_log.size() > 0), 32'd1);
    chk("rand_drops_seen", 32'(to_cnt > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
